// File: rtl/hamming_pkg.sv
// hamming_pkg
// Shared definitions for the SECDED (16,11) Hamming encoder engine and the
// downstream decoder: FSM state type, codeword parity bit positions, the
// codeword builder and a syndrome helper built on top of it.
package hamming_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD_LO = 3'd1,
      ST_RD_HI = 3'd2,
      ST_WR_LO = 3'd3,
      ST_WR_HI = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   // Codeword bit positions of the parity bits; data fills the others.
   localparam int P0 = 0;
   localparam int P1 = 1;
   localparam int P2 = 2;
   localparam int P4 = 4;
   localparam int P8 = 8;

   // Build the 16-bit codeword {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0}.
   function automatic logic [15:0] hamming_parity(input logic [11:1] d);
      logic        p8;
      logic        p4;
      logic        p2;
      logic        p1;
      logic        p0;
      logic [15:0] cw;
      p8 = ^d[11:5];
      p4 = (^d[11:8]) ^ (^d[4:2]);
      p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
      p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
      p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
      cw = {d[11:5], 1'b0, d[4:2], 1'b0, d[1], 3'b000};
      cw[P8] = p8;
      cw[P4] = p4;
      cw[P2] = p2;
      cw[P1] = p1;
      cw[P0] = p0;
      return cw;
   endfunction

   // Returns {overall_parity_mismatch, syndrome[3:0]}. The syndrome is the
   // codeword position of a single flipped bit (0 when only p0 flipped).
   function automatic logic [4:0] hamming_syndrome(input logic [15:0] cw);
      logic [11:1] d;
      logic [15:0] diff;
      d    = {cw[15:9], cw[7:5], cw[3]};
      // Recomputing from the received data leaves data positions equal, so
      // only the parity positions covering the bad bit differ.
      diff = cw ^ hamming_parity(d);
      return {^cw, diff[P8], diff[P4], diff[P2], diff[P1]};
   endfunction

endpackage

// File: rtl/hamming_enc.sv
// hamming_enc
// Purely combinational SECDED encoder wrapping hamming_pkg::hamming_parity.
// Ports:
//   data  input  11  message bits d[11:1] (data[0] = d1)
//   cw    output 16  codeword
module hamming_enc
   import hamming_pkg::*;
(
   input  logic [10:0] data,
   output logic [15:0] cw
);

   assign cw = hamming_parity(data);

endmodule

// File: rtl/hamming_enc_engine.sv
// hamming_enc_engine
// On req, reads NUM_MSG 11-bit messages (two bytes each) from a byte-wide
// data memory and writes each back as a 16-bit SECDED codeword, 4 cycles per
// message (RD_LO, RD_HI, WR_LO, WR_HI).
// Ports:
//   clk        input   1       clock
//   reset      input   1       synchronous active-high reset
//   req        input   1       start request, honoured in IDLE or DONE
//   done       output  1       high while in DONE
//   mem_addr   output  ADDR_W  memory byte address
//   mem_we     output  1       memory write enable
//   mem_wdata  output  8       memory write data
//   mem_rdata  input   8       combinational read data for mem_addr
module hamming_enc_engine
   import hamming_pkg::*;
#(
   parameter int NUM_MSG  = 15,
   parameter int SRC_BASE = 0,
   parameter int DST_BASE = 30,
   parameter int ADDR_W   = 8
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   localparam int                IDX_W    = $clog2(NUM_MSG + 1);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_MSG - 1);
   localparam logic [ADDR_W-1:0] SRC_A    = ADDR_W'(SRC_BASE);
   localparam logic [ADDR_W-1:0] DST_A    = ADDR_W'(DST_BASE);
   localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

   state_t            state;
   logic [IDX_W-1:0]  idx;
   logic [7:0]        lo_r;
   logic [2:0]        hi_r;
   logic [15:0]       cw;
   logic [ADDR_W-1:0] ofs;
   logic              unused_rdata_hi;

   // Only d[11:9] live in the high source byte; the rest is don't-care.
   assign unused_rdata_hi = ^mem_rdata[7:3];

   // Byte offset of message idx; address sums wrap modulo 2^ADDR_W.
   assign ofs = ADDR_W'({idx, 1'b0});

   hamming_enc u_enc (
      .data ({hi_r, lo_r}),
      .cw   (cw)
   );

   // Sequencer: state, message index, latched message bytes and done flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         idx   <= '0;
         lo_r  <= 8'h00;
         hi_r  <= 3'b000;
         done  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req) begin
                  state <= ST_RD_LO;
                  idx   <= '0;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_RD_LO: begin
               lo_r  <= mem_rdata;
               state <= ST_RD_HI;
            end
            ST_RD_HI: begin
               hi_r  <= mem_rdata[2:0];
               state <= ST_WR_LO;
            end
            ST_WR_LO: begin
               state <= ST_WR_HI;
            end
            ST_WR_HI: begin
               if (idx == LAST_IDX) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end else begin
                  idx   <= idx + IDX_W'(1);
                  state <= ST_RD_LO;
               end
            end
            ST_DONE: begin
               if (req) begin
                  state <= ST_RD_LO;
                  idx   <= '0;
                  done  <= 1'b0;
               end else begin
                  state <= ST_DONE;
               end
            end
            default: begin
               state <= ST_IDLE;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // Moore decode of the memory port from state and idx.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = 8'h00;
      case (state)
         ST_RD_LO: begin
            mem_addr = SRC_A + ofs;
         end
         ST_RD_HI: begin
            mem_addr = SRC_A + ofs + ONE_A;
         end
         ST_WR_LO: begin
            // Masked by reset so a reset landing on a write cycle never
            // commits that byte.
            mem_we    = ~reset;
            mem_addr  = DST_A + ofs;
            mem_wdata = cw[7:0];
         end
         ST_WR_HI: begin
            mem_we    = ~reset;
            mem_addr  = DST_A + ofs + ONE_A;
            mem_wdata = cw[15:8];
         end
         default: begin
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = 8'h00;
         end
      endcase
   end

endmodule

// File: tb/tb_hamming_enc_engine.sv
// tb_hamming_enc_engine
// Self-checking bench: byte memory model, table of directed vectors, random
// messages checked against a position-based Hamming reference model.
module tb_hamming_enc_engine;
   import hamming_pkg::*;

   localparam int NUM_MSG  = 15;
   localparam int SRC_BASE = 0;
   localparam int DST_BASE = 30;
   localparam int ADDR_W   = 8;
   localparam int LAT      = 4 * NUM_MSG;

   logic              clk = 1'b0;
   logic              reset;
   logic              req;
   logic              done;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   logic [7:0]        mem [0:255];
   logic              load_en;
   logic [7:0]        load_addr;
   logic [7:0]        load_data;
   logic              clr_stats;
   int                wr_count;
   int                bad_wr_count;

   int                n_checks = 0;
   int                n_fail   = 0;

   logic [7:0]        msg_lo [NUM_MSG];
   logic [7:0]        msg_hi [NUM_MSG];
   logic [15:0]       exp_cw [NUM_MSG];

   typedef struct {
      logic [7:0]  lo;
      logic [7:0]  hi;
      logic [15:0] cw;
   } vec_t;
   vec_t vecs [5];

   hamming_enc_engine #(
      .NUM_MSG  (NUM_MSG),
      .SRC_BASE (SRC_BASE),
      .DST_BASE (DST_BASE),
      .ADDR_W   (ADDR_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .done      (done),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (clr_stats) begin
         wr_count     <= 0;
         bad_wr_count <= 0;
      end else if (mem_we) begin
         wr_count <= wr_count + 1;
         if (mem_addr < 8'(DST_BASE) || mem_addr > 8'(DST_BASE + 2*NUM_MSG - 1))
            bad_wr_count <= bad_wr_count + 1;
      end
      if (load_en) mem[load_addr] <= load_data;
      else if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   // Reference: place data bits at non-power-of-two positions 3..15, each
   // parity bit 2^j covers positions with bit j set, bit 0 makes parity even.
   function automatic logic [15:0] model_cw(input logic [10:0] d);
      logic [15:0] c;
      logic        p;
      int          k;
      c = 16'h0000;
      k = 0;
      for (int pos = 1; pos < 16; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            c[pos] = d[k];
            k++;
         end
      end
      for (int j = 0; j < 4; j++) begin
         p = 1'b0;
         for (int pos = 1; pos < 16; pos++)
            if (pos[j]) p = p ^ c[pos];
         c[1 << j] = p;
      end
      c[0] = ^c[15:1];
      return c;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] v);
      @(negedge clk);
      load_en   = 1'b1;
      load_addr = a;
      load_data = v;
      @(negedge clk);
      load_en   = 1'b0;
   endtask

   task automatic load_all();
      for (int i = 0; i < NUM_MSG; i++) begin
         poke(8'(SRC_BASE + 2*i), msg_lo[i]);
         poke(8'(SRC_BASE + 2*i + 1), msg_hi[i]);
         exp_cw[i] = model_cw({msg_hi[i][2:0], msg_lo[i]});
      end
      for (int a = DST_BASE; a < DST_BASE + 2*NUM_MSG; a++) poke(8'(a), 8'hA5);
      @(negedge clk);
      clr_stats = 1'b1;
      @(negedge clk);
      clr_stats = 1'b0;
   endtask

   task automatic randomize_msgs();
      for (int i = 0; i < NUM_MSG; i++) begin
         msg_lo[i] = 8'($urandom);
         msg_hi[i] = 8'($urandom);
      end
   endtask

   // Pulse req for one edge, then count edges until done (0 on timeout).
   task automatic start_run(output int lat);
      @(negedge clk);
      req = 1'b1;
      @(posedge clk);
      #1;
      req = 1'b0;
      lat = 0;
      for (int k = 1; k <= 4*LAT; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic check_dest(input string tag, input int n_msgs);
      for (int i = 0; i < n_msgs; i++) begin
         check($sformatf("%s_m%0d_lo", tag, i), 32'(mem[DST_BASE + 2*i]), 32'(exp_cw[i][7:0]));
         check($sformatf("%s_m%0d_hi", tag, i), 32'(mem[DST_BASE + 2*i + 1]), 32'(exp_cw[i][15:8]));
      end
   endtask

   initial begin
      int          lat;
      int          lat2;
      logic [15:0] cw;
      logic [3:0]  pos4;

      reset     = 1'b1;
      req       = 1'b0;
      load_en   = 1'b0;
      load_addr = 8'h00;
      load_data = 8'h00;
      clr_stats = 1'b1;
      vecs[0] = '{8'hFF, 8'h07, 16'hFFFF};
      vecs[1] = '{8'h01, 8'h00, 16'h000F};
      vecs[2] = '{8'h00, 8'h04, 16'h8117};
      vecs[3] = '{8'h00, 8'hF8, 16'h0000};
      vecs[4] = '{8'hFF, 8'hFF, 16'hFFFF};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_done", 32'(done), 32'd0);
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_wdata", 32'(mem_wdata), 32'd0);
      reset     = 1'b0;
      clr_stats = 1'b0;

      // All-zero messages
      for (int i = 0; i < NUM_MSG; i++) begin
         msg_lo[i] = 8'h00;
         msg_hi[i] = 8'h00;
      end
      load_all();
      start_run(lat);
      check("zero_latency", 32'(lat), 32'(LAT));
      check_dest("zero", NUM_MSG);
      check("zero_wr_count", 32'(wr_count), 32'(2*NUM_MSG));
      check("zero_bad_wr", 32'(bad_wr_count), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("zero_done_hold", 32'(done), 32'd1);
      check("done_we_low", 32'(mem_we), 32'd0);
      check("done_addr_zero", 32'(mem_addr), 32'd0);

      // Table vectors in messages 0..4, random in the rest
      randomize_msgs();
      for (int i = 0; i < 5; i++) begin
         msg_lo[i] = vecs[i].lo;
         msg_hi[i] = vecs[i].hi;
      end
      load_all();
      for (int i = 0; i < 5; i++) exp_cw[i] = vecs[i].cw;
      start_run(lat);
      check("tbl_latency", 32'(lat), 32'(LAT));
      check_dest("tbl", NUM_MSG);

      // Random messages plus single-bit corruption syndrome checks
      for (int r = 0; r < 2; r++) begin
         randomize_msgs();
         load_all();
         start_run(lat);
         check("rnd_latency", 32'(lat), 32'(LAT));
         check_dest("rnd", NUM_MSG);
         check("rnd_bad_wr", 32'(bad_wr_count), 32'd0);
      end
      for (int i = 0; i < NUM_MSG; i++) begin
         cw = {mem[DST_BASE + 2*i + 1], mem[DST_BASE + 2*i]};
         check($sformatf("syn_clean_m%0d", i), 32'(hamming_syndrome(cw)), 32'd0);
         for (int b = 0; b < 16; b++) begin
            pos4 = b[3:0];
            check($sformatf("syn_m%0d_b%0d", i, b),
                  32'(hamming_syndrome(cw ^ (16'h0001 << b))), 32'({1'b1, pos4}));
         end
      end

      // req held high across DONE: one-cycle done, immediate restart
      randomize_msgs();
      load_all();
      @(negedge clk);
      req = 1'b1;
      @(posedge clk);
      #1;
      lat = 0;
      for (int k = 1; k <= 4*LAT; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = k;
            break;
         end
      end
      check("held_latency", 32'(lat), 32'(LAT));
      @(posedge clk);
      #1;
      check("held_done_drop", 32'(done), 32'd0);
      lat2 = 1;
      for (int k = 2; k <= 4*LAT; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat2 = k;
            break;
         end
      end
      req = 1'b0;
      check("held_relatency", 32'(lat2), 32'(LAT + 1));
      repeat (2) @(posedge clk);
      #1;
      check("held_done_stay", 32'(done), 32'd1);
      check_dest("held", NUM_MSG);

      // Reset in WR_LO of message 5, then a clean rerun
      randomize_msgs();
      load_all();
      @(negedge clk);
      req = 1'b1;
      @(posedge clk);
      #1;
      req = 1'b0;
      repeat (22) @(posedge clk);
      #1;
      check("mid_wrlo_we", 32'(mem_we), 32'd1);
      check("mid_wrlo_addr", 32'(mem_addr), 32'(DST_BASE + 10));
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_we", 32'(mem_we), 32'd0);
      check("mid_rst_addr", 32'(mem_addr), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("mid_idle_we", 32'(mem_we), 32'd0);
      check_dest("mid_part", 5);
      for (int a = DST_BASE + 10; a < DST_BASE + 2*NUM_MSG; a++)
         check($sformatf("mid_untouched_%0d", a), 32'(mem[a]), 32'h0000_00A5);
      start_run(lat);
      check("mid_rerun_latency", 32'(lat), 32'(LAT));
      check_dest("mid_rerun", NUM_MSG);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
